// File: rtl/io_bridge_pkg.sv
// Shared types and default parameter values for the io_bridge CPU/host port bridge.
package io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } rd_state_e;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IN_DEPTH  = 4;
    localparam int DEF_OUT_DEPTH = 4;
    localparam int DEF_TIMEOUT   = 64;

endpackage

// File: rtl/io_bridge_fifo.sv
// io_fifo: synchronous FIFO with a combinational head. A push is ignored while
// the FIFO is full and a pop is ignored while it is empty.
module io_fifo
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_IN_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("io_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: host<->CPU bridge with an input FIFO read by a request/ack FSM and
// an output FIFO written by the CPU. Define IO_BRIDGE_TIMEOUT_EN to bound WAIT.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IN_DEPTH  = DEF_IN_DEPTH,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    input  logic              cpu_in_req,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_ack,
    output logic              cpu_in_timeout,
    output logic              status,
    input  logic              cpu_out_we,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              cpu_out_ready,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready
);

    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("io_bridge: TIMEOUT must be in 1..65535");
        end
    endgenerate

    rd_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] in_head;
    logic              in_full;
    logic              in_empty;
    logic              in_pop;
    logic              out_full;
    logic              out_empty;
    logic              wait_expired;

    io_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (host_in_valid),
        .push_data (host_in_data),
        .pop       (in_pop),
        .head      (in_head),
        .full      (in_full),
        .empty     (in_empty)
    );

    io_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cpu_out_we),
        .push_data (cpu_out_data),
        .pop       (host_out_ready),
        .head      (host_out_data),
        .full      (out_full),
        .empty     (out_empty)
    );

    assign host_in_ready  = !in_full;
    assign status         = !in_empty;
    assign cpu_out_ready  = !out_full;
    assign host_out_valid = !out_empty;
    assign cpu_in_ack     = (state_q == ST_ACK);
    assign cpu_in_data    = data_q;

`ifdef IO_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;

    assign wait_expired   = (wait_cnt_q == 16'(TIMEOUT - 1));
    assign cpu_in_timeout = timeout_q;

    // Counts WAIT cycles; any exit from WAIT restarts it from zero.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_WAIT && state_d == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
        timeout_d = (state_q == ST_WAIT) && cpu_in_req && in_empty && wait_expired;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`else
    assign wait_expired   = 1'b0;
    assign cpu_in_timeout = 1'b0;
`endif

    // A word already present wins over an expiring wait in the same cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        in_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_in_req) begin
                    if (!in_empty) begin
                        state_d = ST_ACK;
                        in_pop  = 1'b1;
                        data_d  = in_head;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cpu_in_req) begin
                    state_d = ST_IDLE;
                end else if (!in_empty) begin
                    state_d = ST_ACK;
                    in_pop  = 1'b1;
                    data_d  = in_head;
                end else if (wait_expired) begin
                    state_d = ST_ACK;
                    data_d  = '0;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Randomized bench for io_bridge: a queue-based model of both FIFOs and the
// request/ack read protocol predicts every output each cycle.
module tb_io_bridge;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] host_in_data;
    logic          host_in_valid;
    logic          host_in_ready;
    logic          cpu_in_req;
    logic [DW-1:0] cpu_in_data;
    logic          cpu_in_ack;
    logic          cpu_in_timeout;
    logic          status;
    logic          cpu_out_we;
    logic [DW-1:0] cpu_out_data;
    logic          cpu_out_ready;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid;
    logic          host_out_ready;

    io_bridge #(
        .DATA_W    (DW),
        .IN_DEPTH  (DEPTH),
        .OUT_DEPTH (DEPTH),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .cpu_in_req     (cpu_in_req),
        .cpu_in_data    (cpu_in_data),
        .cpu_in_ack     (cpu_in_ack),
        .cpu_in_timeout (cpu_in_timeout),
        .status         (status),
        .cpu_out_we     (cpu_out_we),
        .cpu_out_data   (cpu_out_data),
        .cpu_out_ready  (cpu_out_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    bit            exp_ack;
    bit            exp_to;
    logic [DW-1:0] exp_data;
    bit            waiting;
    int            wait_cycles;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        in_q.delete();
        out_q.delete();
        exp_ack     = 1'b0;
        exp_to      = 1'b0;
        exp_data    = '0;
        waiting     = 1'b0;
        wait_cycles = 0;
    endtask

    task automatic applyStimulus(input int p_valid, input int p_req, input int p_we, input int p_ready);
        host_in_valid  = ($urandom_range(0, 99) < p_valid);
        host_in_data   = DW'($urandom_range(0, 65535));
        cpu_in_req     = ($urandom_range(0, 99) < p_req);
        cpu_out_we     = ($urandom_range(0, 99) < p_we);
        cpu_out_data   = DW'($urandom_range(0, 65535));
        host_out_ready = ($urandom_range(0, 99) < p_ready);
    endtask

    task automatic checkAll();
        checkOutput("host_in_ready", 32'(host_in_ready), 32'(in_q.size() < DEPTH));
        checkOutput("status", 32'(status), 32'(in_q.size() > 0));
        checkOutput("cpu_out_ready", 32'(cpu_out_ready), 32'(out_q.size() < DEPTH));
        checkOutput("host_out_valid", 32'(host_out_valid), 32'(out_q.size() > 0));
        if (out_q.size() > 0) begin
            checkOutput("host_out_data", 32'(host_out_data), 32'(out_q[0]));
        end
        checkOutput("cpu_in_ack", 32'(cpu_in_ack), 32'(exp_ack));
        checkOutput("cpu_in_data", 32'(cpu_in_data), 32'(exp_data));
        checkOutput("cpu_in_timeout", 32'(cpu_in_timeout), 32'(exp_to));
    endtask

    // One clock edge of the bridge, from the inputs held across it.
    task automatic modelStep();
        bit in_had  = (in_q.size() > 0);
        bit in_full = (in_q.size() >= DEPTH);
        bit out_had = (out_q.size() > 0);
        bit out_full = (out_q.size() >= DEPTH);
        if (exp_ack) begin
            exp_ack     = 1'b0;
            exp_to      = 1'b0;
            waiting     = 1'b0;
            wait_cycles = 0;
        end else if (cpu_in_req && in_had) begin
            exp_ack     = 1'b1;
            exp_to      = 1'b0;
            exp_data    = in_q.pop_front();
            waiting     = 1'b0;
            wait_cycles = 0;
        end else if (cpu_in_req) begin
            if (waiting) begin
                wait_cycles++;
                if (TIMEOUT_EN && wait_cycles == TO) begin
                    exp_ack     = 1'b1;
                    exp_to      = 1'b1;
                    exp_data    = '0;
                    waiting     = 1'b0;
                    wait_cycles = 0;
                end
            end else begin
                waiting     = 1'b1;
                wait_cycles = 0;
            end
        end else begin
            waiting     = 1'b0;
            wait_cycles = 0;
        end
        if (host_in_valid && !in_full) in_q.push_back(host_in_data);
        if (host_out_ready && out_had) void'(out_q.pop_front());
        if (cpu_out_we && !out_full) out_q.push_back(cpu_out_data);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        host_in_valid  = 1'b0;
        cpu_in_req     = 1'b0;
        cpu_out_we     = 1'b0;
        host_out_ready = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkAll();
    endtask

    // Phase table: valid%, req%, we%, ready%, cycles, reset cycle (-1 = none).
    int ph_valid [6] = '{50, 90,  0, 10, 100,  0};
    int ph_req   [6] = '{50, 30, 100, 70,  20, 100};
    int ph_we    [6] = '{50, 90, 20, 50, 100, 30};
    int ph_ready [6] = '{50, 10, 90, 50, 100, 60};
    int ph_len   [6] = '{300, 200, 40, 250, 200, 40};
    int ph_rst   [6] = '{-1, -1, -1, -1, -1, 5};

    initial begin
        rst_n          = 1'b1;
        host_in_data   = '0;
        host_in_valid  = 1'b0;
        cpu_in_req     = 1'b0;
        cpu_out_we     = 1'b0;
        cpu_out_data   = '0;
        host_out_ready = 1'b0;
        modelReset();
        #1;
        $display("[TB] reset and randomized run, timeout enabled=%0d", TIMEOUT_EN);
        resetPulse();
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                if (c == ph_rst[p]) begin
                    resetPulse();
                end
                @(negedge clk);
                applyStimulus(ph_valid[p], ph_req[p], ph_we[p], ph_ready[p]);
                #1;
                checkAll();
                @(posedge clk);
                modelStep();
            end
        end
        @(negedge clk);
        #1;
        checkAll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
